toggle_ctrl: RTL and testbench
==============================

Name: toggle_ctrl

Overview:
- Timed pattern generator for the NAND-flash interface sequencer.
- On an `enable` pulse it latches a cycle count and two 5-bit control vectors.
- It drives `outputVEC` as alternating setup/hold phases for the requested number of toggles, then pulses `done`.
- It sits between the command FSM and the flash pin drivers; debug taps expose internal state.

Parameters:
- SETUP_CYCLES, 4, clocks per setup phase (4-bit, legal 1..15)
- HOLD_CYCLES, 4, clocks per hold phase (4-bit, legal 1..15)
- IDLE_VEC, 5'b11010, `outputVEC` value in reset and IDLE

Ports:
- clk  in  1  system clock, rising edge (50 MHz nominal)
- reset  in  1  asynchronous, active-low reset
- enable  in  1  start request; sampled only in IDLE
- cntUPTO  in  12  number of setup+hold toggles to perform
- setupSignal  in  5  vector driven during each setup phase
- holdSignal  in  5  vector driven during each hold phase
- done  out  1  one-cycle completion pulse
- outputVEC  out  5  registered control vector to pins
- state_tb  out  2  current FSM state (debug)
- delayCNT_tb  out  4  in-phase delay counter (debug)
- dummy_cnt  out  1  LSB of completed-toggle counter (debug)

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-low.
- Reset (reset=0) forces:
  - state=IDLE, `outputVEC`=IDLE_VEC
  - `done`=0, `delayCNT`=0, toggle counter=0, latched registers=0
  - This applies immediately, including mid-operation.
- All outputs are registered.
- FSM encoding: IDLE=0, SETUP=1, HOLD=2, DONE=3.
- IDLE:
  - On `enable`=1 at a rising edge, latch `cntUPTO`, `setupSignal` and `holdSignal`.
  - If latched count is 0: go to DONE (no toggles).
  - Otherwise: go to SETUP and drive `outputVEC`=setupSignal on that same edge.
- SETUP:
  - `delayCNT` counts 0..SETUP_CYCLES-1; `outputVEC`=latched setupSignal.
  - On the edge where `delayCNT`=SETUP_CYCLES-1: clear `delayCNT`, go to HOLD, drive `outputVEC`=latched holdSignal.
- HOLD:
  - `delayCNT` counts 0..HOLD_CYCLES-1.
  - At the last count the toggle counter increments.
  - If the new count equals the latched count: go to DONE.
  - Else: go to SETUP and drive setupSignal.
- DONE:
  - Lasts exactly one cycle; `done`=1 only in this state.
  - `outputVEC` holds the last hold value.
  - Next edge: go to IDLE, `outputVEC`=IDLE_VEC, `done`=0, counters cleared.
- `enable` and input changes while not in IDLE are ignored; only latched copies are used.
- A new `enable` is accepted on the first IDLE cycle after DONE, so back-to-back operations are allowed.
- Toggle counter is 12 bits; `cntUPTO`=4095 completes without wrap.
- Latency: N toggles take N*(SETUP_CYCLES+HOLD_CYCLES) cycles, plus 1 DONE cycle after the enable-sampling edge.

Optional Feature:
- Macro TOGGLE_DEBUG_EN.
- Defined: `state_tb`, `delayCNT_tb` and `dummy_cnt` reflect live state, delay counter and toggle-count LSB.
- Undefined: the three debug ports remain present but are driven constant 0; no functional change elsewhere.

Test Plan:
- Reset: hold reset=0 for 3 cycles with enable=1 -> `outputVEC`=11010, `done`=0, `state_tb`=0 throughout; no operation starts.
- Single toggle: cntUPTO=1, setupSignal=10010, holdSignal=11010, enable pulsed 1 cycle -> `outputVEC` 10010 for 4 cycles, 11010 for 4 cycles; `done`=1 for exactly 1 cycle, 9 cycles after the enable edge; `outputVEC` back to 11010.
- Four toggles: cntUPTO=4, setup=11010, hold=10010, enabled 1 cycle after `done` -> 4 alternations of 4+4 cycles (32 cycles); `dummy_cnt` toggles each completed pair; `done` pulses once at cycle 33.
- Zero count: cntUPTO=0 -> `done` pulses on the cycle after the enable edge; `outputVEC` stays 11010.
- Busy ignore: during cntUPTO=2 run, assert enable and change cntUPTO=7 and both vectors -> run still completes after 2 toggles with original vectors.
- Reset mid-run: drop reset during HOLD -> immediate IDLE, `outputVEC`=11010, no `done` pulse.

Source files
------------

// File: rtl/toggle_ctrl.sv
// Timed setup/hold pattern generator for the NAND-flash pin sequencer.
// Define TOGGLE_DEBUG_EN to drive live state on state_tb/delayCNT_tb/dummy_cnt (otherwise tied to 0).
module toggle_ctrl #(
  parameter logic [3:0] SETUP_CYCLES = 4'd4,
  parameter logic [3:0] HOLD_CYCLES  = 4'd4,
  parameter logic [4:0] IDLE_VEC     = 5'b11010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] cntUPTO,
  input  logic [4:0]  setupSignal,
  input  logic [4:0]  holdSignal,
  output logic        done,
  output logic [4:0]  outputVEC,
  output logic [1:0]  state_tb,
  output logic [3:0]  delayCNT_tb,
  output logic        dummy_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  delay_reg, delay_next;
  logic [11:0] toggle_reg, toggle_next;
  logic [11:0] upto_reg, upto_next;
  logic [4:0]  setup_reg, setup_next;
  logic [4:0]  hold_reg, hold_next;
  logic [4:0]  vec_reg, vec_next;
  logic        done_reg, done_next;

  logic setup_last, hold_last, last_toggle;

  assign setup_last  = (delay_reg == SETUP_CYCLES - 4'd1);
  assign hold_last   = (delay_reg == HOLD_CYCLES - 4'd1);
  assign last_toggle = ((toggle_reg + 12'd1) == upto_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      delay_reg  <= 4'd0;
      toggle_reg <= 12'd0;
      upto_reg   <= 12'd0;
      setup_reg  <= 5'd0;
      hold_reg   <= 5'd0;
      vec_reg    <= IDLE_VEC;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      delay_reg  <= delay_next;
      toggle_reg <= toggle_next;
      upto_reg   <= upto_next;
      setup_reg  <= setup_next;
      hold_reg   <= hold_next;
      vec_reg    <= vec_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (enable) state_next = (cntUPTO == 12'd0) ? DONE : SETUP;
      SETUP:   if (setup_last) state_next = HOLD;
      HOLD:    if (hold_last) state_next = last_toggle ? DONE : SETUP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of every registered output and counter.
  always_comb begin
    delay_next  = delay_reg;
    toggle_next = toggle_reg;
    upto_next   = upto_reg;
    setup_next  = setup_reg;
    hold_next   = hold_reg;
    vec_next    = vec_reg;
    done_next   = (state_next == DONE);
    unique case (state_reg)
      IDLE: begin
        delay_next  = 4'd0;
        toggle_next = 12'd0;
        if (enable) begin
          upto_next  = cntUPTO;
          setup_next = setupSignal;
          hold_next  = holdSignal;
          if (cntUPTO != 12'd0) vec_next = setupSignal;
        end
      end
      SETUP: begin
        if (setup_last) begin
          delay_next = 4'd0;
          vec_next   = hold_reg;
        end else begin
          delay_next = delay_reg + 4'd1;
        end
      end
      HOLD: begin
        if (hold_last) begin
          delay_next  = 4'd0;
          toggle_next = toggle_reg + 12'd1;
          vec_next    = last_toggle ? hold_reg : setup_reg;
        end else begin
          delay_next = delay_reg + 4'd1;
        end
      end
      DONE: begin
        delay_next  = 4'd0;
        toggle_next = 12'd0;
        vec_next    = IDLE_VEC;
      end
      default: vec_next = IDLE_VEC;
    endcase
  end

  assign done      = done_reg;
  assign outputVEC = vec_reg;

`ifdef TOGGLE_DEBUG_EN
  assign state_tb    = state_reg;
  assign delayCNT_tb = delay_reg;
  assign dummy_cnt   = toggle_reg[0];
`else
  assign state_tb    = 2'd0;
  assign delayCNT_tb = 4'd0;
  assign dummy_cnt   = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_ctrl.sv
// Scoreboard bench for toggle_ctrl: stimulus queues expected operations, a negedge monitor checks every cycle.
module tb_toggle_ctrl;

  localparam int S = 4;
  localparam int H = 4;
  localparam int P = S + H;
  localparam logic [4:0] IDLE_V = 5'b11010;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] cnt_upto;
  logic [4:0]  setup_sig;
  logic [4:0]  hold_sig;
  logic        done;
  logic [4:0]  output_vec;
  logic [1:0]  state_tb;
  logic [3:0]  delay_tb;
  logic        dummy_cnt;

  toggle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cntUPTO     (cnt_upto),
    .setupSignal (setup_sig),
    .holdSignal  (hold_sig),
    .done        (done),
    .outputVEC   (output_vec),
    .state_tb    (state_tb),
    .delayCNT_tb (delay_tb),
    .dummy_cnt   (dummy_cnt)
  );

  typedef struct {
    int         start;
    int         n;
    logic [4:0] s;
    logic [4:0] h;
  } op_t;

  op_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Monitor: expected outputs derived from the head operation and its start edge.
  logic [4:0] m_vec;
  logic       m_done, m_dum, m_pop;
  logic [1:0] m_st;
  logic [3:0] m_dly;
  int         m_k, m_ph;

  always @(negedge clk) begin
    m_vec = IDLE_V; m_done = 1'b0; m_st = 2'd0; m_dly = 4'd0; m_dum = 1'b0; m_pop = 1'b0;
    m_k = 0; m_ph = 0;
    if (q.size() > 0 && reset) begin
      m_k  = cyc - q[0].start;
      m_ph = m_k % P;
      if (m_k < q[0].n * P) begin
        m_vec = (m_ph < S) ? q[0].s : q[0].h;
        m_st  = (m_ph < S) ? 2'd1 : 2'd2;
        m_dly = (m_ph < S) ? 4'(m_ph) : 4'(m_ph - S);
        m_dum = 1'((m_k / P) & 1);
      end else begin
        m_done = 1'b1;
        m_st   = 2'd3;
        m_vec  = (q[0].n == 0) ? IDLE_V : q[0].h;
        m_dum  = 1'(q[0].n & 1);
        m_pop  = 1'b1;
      end
    end
`ifndef TOGGLE_DEBUG_EN
    m_st = 2'd0; m_dly = 4'd0; m_dum = 1'b0;
`endif
    chk("outvec", int'(output_vec), int'(m_vec));
    chk("done", int'(done), int'(m_done));
    chk("state_tb", int'(state_tb), int'(m_st));
    chk("delay_tb", int'(delay_tb), int'(m_dly));
    chk("dummy_cnt", int'(dummy_cnt), int'(m_dum));
    if (m_pop) begin
      $display("op n=%0d setup=%b hold=%b done after %0d cycles", q[0].n, q[0].s, q[0].h, m_k);
      void'(q.pop_front());
    end
  end

  task automatic start_op(input int n, input logic [4:0] s, input logic [4:0] h);
    op_t o;
    @(negedge clk);
    cnt_upto  = n[11:0];
    setup_sig = s;
    hold_sig  = h;
    enable    = 1'b1;
    @(posedge clk);
    #1;
    o.start = cyc; o.n = n; o.s = s; o.h = h;
    q.push_back(o);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout cyc=%0d got=pending exp=done", cyc);
      q.delete();
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; cnt_upto = 12'd5; setup_sig = 5'b00001; hold_sig = 5'b00010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    repeat (2) @(posedge clk);

    // Single toggle, then back-to-back four toggles.
    start_op(1, 5'b10010, 5'b11010);
    wait_done(1 * P + 20);
    start_op(4, 5'b11010, 5'b10010);
    wait_done(4 * P + 20);

    // Zero count.
    start_op(0, 5'b00111, 5'b01000);
    wait_done(20);

    // Inputs and enable ignored while busy.
    start_op(2, 5'b10110, 5'b01101);
    repeat (3) @(negedge clk);
    enable = 1'b1; cnt_upto = 12'd7; setup_sig = 5'b00000; hold_sig = 5'b11111;
    @(negedge clk);
    enable = 1'b0;
    wait_done(2 * P + 20);

    // Asynchronous reset in the middle of a HOLD phase.
    start_op(3, 5'b01010, 5'b10101);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);

    start_op(1, 5'b00011, 5'b11000);
    wait_done(1 * P + 20);

    // Full-range count must finish without wrapping.
    start_op(4095, 5'b00101, 5'b11100);
    wait_done(4095 * P + 20);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
